// File: rtl/ex_stage_pkg.sv
// ============================================================================
// Module : ex_stage_pkg
// Brief  : Shared opcodes, iteration count and FSM type for the execute stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ex_stage_pkg;

    localparam int ALU_OP_W     = 5;
    localparam int MUL_DIV_ITER = 16;

    localparam logic [ALU_OP_W-1:0] ALU_NOP  = 5'd0;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 5'd2;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 5'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'd4;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 5'd5;
    localparam logic [ALU_OP_W-1:0] ALU_NOT  = 5'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 5'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 5'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 5'd9;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 5'd10;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 5'd11;
    localparam logic [ALU_OP_W-1:0] ALU_CMP  = 5'd12;
    localparam logic [ALU_OP_W-1:0] ALU_LI   = 5'd13;
    localparam logic [ALU_OP_W-1:0] ALU_MUL  = 5'd14;
    localparam logic [ALU_OP_W-1:0] ALU_DIVU = 5'd15;
    localparam logic [ALU_OP_W-1:0] ALU_REMU = 5'd16;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    function automatic logic is_multi_cycle(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_stage_muldiv_unit.sv
// ============================================================================
// Module : muldiv_unit
// Brief  : Iterative 16-step shift-add multiplier / restoring unsigned divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int CNT_W = $clog2(MUL_DIV_ITER);
    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(MUL_DIV_ITER - 1);

    md_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_a;     // multiplicand (MUL) or dividend/quotient shifter (DIV)
    logic [DATA_W-1:0] r_b;     // multiplier (MUL) or divisor (DIV)
    logic [DATA_W:0]   r_acc;   // product (MUL) or partial remainder (DIV)

    logic [DATA_W:0]   w_rem_sh;
    logic [DATA_W:0]   w_rem_sub;
    logic              w_rem_ge;
    logic              w_is_mul;
    logic              w_start_div;

    assign w_rem_sh    = {r_acc[DATA_W-1:0], r_a[DATA_W-1]};
    assign w_rem_ge    = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_sub   = w_rem_sh - {1'b0, r_b};
    assign w_is_mul    = (r_op == OP_W'(ALU_MUL));
    assign w_start_div = (op == OP_W'(ALU_DIVU)) || (op == OP_W'(ALU_REMU));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (start && !flush) begin
                        r_op  <= op;
                        r_cnt <= '0;
                        if (w_start_div && (b == '0)) begin
                            // Divide by zero resolves immediately: all-ones quotient, dividend as remainder
                            r_a     <= '1;
                            r_b     <= b;
                            r_acc   <= {1'b0, a};
                            r_state <= MD_DONE;
                        end else begin
                            r_a     <= a;
                            r_b     <= b;
                            r_acc   <= '0;
                            r_state <= MD_BUSY;
                        end
                    end
                end
                MD_BUSY: begin
                    if (flush) begin
                        r_state <= MD_IDLE;
                    end else begin
                        if (w_is_mul) begin
                            r_acc <= {1'b0, r_acc[DATA_W-1:0] + (r_b[0] ? r_a : '0)};
                            r_a   <= {r_a[DATA_W-2:0], 1'b0};
                            r_b   <= {1'b0, r_b[DATA_W-1:1]};
                        end else begin
                            r_acc <= w_rem_ge ? w_rem_sub : w_rem_sh;
                            r_a   <= {r_a[DATA_W-2:0], w_rem_ge};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_last_iter) begin
                            r_state <= MD_DONE;
                        end
                    end
                end
                MD_DONE: begin
                    r_state <= MD_IDLE;
                end
                default: begin
                    r_state <= MD_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == MD_BUSY);
    assign done = (r_state == MD_DONE);

    always_comb begin
        result = r_acc[DATA_W-1:0];
        if (r_op == OP_W'(ALU_DIVU)) begin
            result = r_a;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// Module : ex_stage
// Brief  : THCO-MIPS execute stage: single-cycle ALU plus iterative mul/div.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [OP_W-1:0]   aluOp_i,
    input  logic [DATA_W-1:0] operand1_i,
    input  logic [DATA_W-1:0] operand2_i,
    input  logic              wReg_i,
    input  logic [ADDR_W-1:0] wRegAddr_i,
    output logic              wReg_o,
    output logic [ADDR_W-1:0] wRegAddr_o,
    output logic [DATA_W-1:0] wData_o,
    output logic              stallReq_o
);

    logic              w_is_md;
    logic              w_md_busy;
    logic              w_md_done;
    logic              w_md_idle;
    logic              w_md_start;
    logic [DATA_W-1:0] w_md_result;
    logic [DATA_W-1:0] w_alu;
    logic [4:0]        w_shamt;

    logic              r_wreg;
    logic [ADDR_W-1:0] r_waddr;

    assign w_is_md    = is_multi_cycle(ALU_OP_W'(aluOp_i));
    assign w_md_idle  = !w_md_busy && !w_md_done;
    assign w_md_start = w_is_md && w_md_idle && !flush_i;

    // A zero shift field encodes a shift of 8
    assign w_shamt = (operand2_i[3:0] == 4'd0) ? 5'd8 : {1'b0, operand2_i[3:0]};

    muldiv_unit #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (w_is_md),
        .op     (aluOp_i),
        .a      (operand1_i),
        .b      (operand2_i),
        .flush  (flush_i),
        .busy   (w_md_busy),
        .done   (w_md_done),
        .result (w_md_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wreg  <= 1'b0;
            r_waddr <= '0;
        end else if (w_md_start) begin
            r_wreg  <= wReg_i;
            r_waddr <= wRegAddr_i;
        end
    end

    always_comb begin
        w_alu = '0;
        case (aluOp_i)
            OP_W'(ALU_ADD):  w_alu = operand1_i + operand2_i;
            OP_W'(ALU_SUB):  w_alu = operand1_i - operand2_i;
            OP_W'(ALU_AND):  w_alu = operand1_i & operand2_i;
            OP_W'(ALU_OR):   w_alu = operand1_i | operand2_i;
            OP_W'(ALU_XOR):  w_alu = operand1_i ^ operand2_i;
            OP_W'(ALU_NOT):  w_alu = ~operand1_i;
            OP_W'(ALU_SLL):  w_alu = operand1_i << w_shamt;
            OP_W'(ALU_SRL):  w_alu = operand1_i >> w_shamt;
            OP_W'(ALU_SRA):  w_alu = $signed(operand1_i) >>> w_shamt;
            OP_W'(ALU_SLT):  w_alu = {{(DATA_W-1){1'b0}}, ($signed(operand1_i) < $signed(operand2_i))};
            OP_W'(ALU_SLTU): w_alu = {{(DATA_W-1){1'b0}}, (operand1_i < operand2_i)};
            OP_W'(ALU_CMP):  w_alu = {{(DATA_W-1){1'b0}}, (operand1_i != operand2_i)};
            OP_W'(ALU_LI):   w_alu = operand2_i;
            default:         w_alu = '0;
        endcase
    end

    // Reset gates the outputs directly so an abort is visible without waiting for a clock
    always_comb begin
        wReg_o     = 1'b0;
        wRegAddr_o = '0;
        wData_o    = '0;
        stallReq_o = 1'b0;
        if (!rst) begin
            if (w_md_done) begin
                wData_o    = w_md_result;
                wReg_o     = r_wreg && !flush_i;
                wRegAddr_o = r_waddr;
            end else if (w_md_busy || w_is_md) begin
                stallReq_o = !flush_i;
            end else begin
                wData_o    = w_alu;
                wReg_o     = wReg_i && (aluOp_i != OP_W'(ALU_NOP)) && !flush_i;
                wRegAddr_o = wRegAddr_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// Module : tb_ex_stage
// Brief  : Directed self-checking bench for ex_stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [4:0]  aluOp_i;
    logic [15:0] operand1_i;
    logic [15:0] operand2_i;
    logic        wReg_i;
    logic [3:0]  wRegAddr_i;
    logic        wReg_o;
    logic [3:0]  wRegAddr_o;
    logic [15:0] wData_o;
    logic        stallReq_o;

    int tests = 0;
    int fails = 0;

    ex_stage #(.DATA_W(16), .ADDR_W(4), .OP_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .aluOp_i    (aluOp_i),
        .operand1_i (operand1_i),
        .operand2_i (operand2_i),
        .wReg_i     (wReg_i),
        .wRegAddr_i (wRegAddr_i),
        .wReg_o     (wReg_o),
        .wRegAddr_o (wRegAddr_o),
        .wData_o    (wData_o),
        .stallReq_o (stallReq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] addr);
        aluOp_i    = op;
        operand1_i = a;
        operand2_i = b;
        wReg_i     = 1'b1;
        wRegAddr_i = addr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives a multi-cycle op and counts stall cycles; returns at the negedge of the first non-stall cycle
    task automatic run_md(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] addr, output int n);
        n = 0;
        drive(op, a, b, addr);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stallReq_o) break;
            n++;
            next_cycle();
        end
    endtask

    int  n;
    logic seen_wreg;
    logic seen_stall;

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        drive(ALU_ADD, 16'h1234, 16'h1111, 4'd9);
        #2;
        check("rst_wreg",  {31'd0, wReg_o}, 32'd0);
        check("rst_waddr", {28'd0, wRegAddr_o}, 32'd0);
        check("rst_wdata", {16'd0, wData_o}, 32'd0);
        check("rst_stall", {31'd0, stallReq_o}, 32'd0);
        next_cycle();
        rst = 1'b0;

        drive(ALU_ADD, 16'h7FFF, 16'h0001, 4'd5);
        @(negedge clk);
        check("add_data",  {16'd0, wData_o}, 32'h8000);
        check("add_wreg",  {31'd0, wReg_o}, 32'd1);
        check("add_waddr", {28'd0, wRegAddr_o}, 32'd5);
        check("add_stall", {31'd0, stallReq_o}, 32'd0);
        next_cycle();

        drive(ALU_SRA, 16'h8000, 16'h0000, 4'd1);
        @(negedge clk);
        check("sra_by0", {16'd0, wData_o}, 32'hFF80);
        next_cycle();
        drive(ALU_SLL, 16'h0001, 16'h0010, 4'd1);
        @(negedge clk);
        check("sll_by0", {16'd0, wData_o}, 32'h0100);
        next_cycle();
        drive(ALU_SLT, 16'hFFFF, 16'h0001, 4'd1);
        @(negedge clk);
        check("slt", {16'd0, wData_o}, 32'd1);
        next_cycle();
        drive(ALU_SLTU, 16'hFFFF, 16'h0001, 4'd1);
        @(negedge clk);
        check("sltu", {16'd0, wData_o}, 32'd0);
        next_cycle();
        drive(ALU_CMP, 16'h00AA, 16'h00AA, 4'd1);
        @(negedge clk);
        check("cmp_eq", {16'd0, wData_o}, 32'd0);
        next_cycle();
        drive(ALU_SUB, 16'h0000, 16'h0001, 4'd2);
        @(negedge clk);
        check("sub_wrap", {16'd0, wData_o}, 32'hFFFF);
        next_cycle();
        drive(ALU_NOP, 16'h1111, 16'h2222, 4'd2);
        @(negedge clk);
        check("nop_data", {16'd0, wData_o}, 32'd0);
        check("nop_wreg", {31'd0, wReg_o}, 32'd0);
        next_cycle();

        run_md(ALU_MUL, 16'h0123, 16'h0010, 4'd3, n);
        check("mul_stalls", n, 32'd17);
        check("mul_data",  {16'd0, wData_o}, 32'h1230);
        check("mul_wreg",  {31'd0, wReg_o}, 32'd1);
        check("mul_waddr", {28'd0, wRegAddr_o}, 32'd3);
        next_cycle();

        run_md(ALU_MUL, 16'h0003, 16'h0005, 4'd4, n);
        check("mul2_stalls", n, 32'd17);
        check("mul2_data", {16'd0, wData_o}, 32'd15);
        check("mul2_waddr", {28'd0, wRegAddr_o}, 32'd4);
        next_cycle();

        run_md(ALU_DIVU, 16'd100, 16'd7, 4'd6, n);
        check("divu_stalls", n, 32'd17);
        check("divu_data", {16'd0, wData_o}, 32'd14);
        next_cycle();
        run_md(ALU_REMU, 16'd100, 16'd7, 4'd6, n);
        check("remu_stalls", n, 32'd17);
        check("remu_data", {16'd0, wData_o}, 32'd2);
        next_cycle();
        run_md(ALU_DIVU, 16'd1234, 16'd0, 4'd6, n);
        check("div0_stalls", n, 32'd1);
        check("div0_data", {16'd0, wData_o}, 32'hFFFF);
        check("div0_wreg", {31'd0, wReg_o}, 32'd1);
        next_cycle();

        // Reset at BUSY cycle 8
        drive(ALU_MUL, 16'h0007, 16'h0009, 4'd8);
        @(negedge clk);
        for (int i = 0; i < 8; i++) next_cycle();
        @(negedge clk);
        check("pre_rst_stall", {31'd0, stallReq_o}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_rst_stall", {31'd0, stallReq_o}, 32'd0);
        check("abort_rst_wreg",  {31'd0, wReg_o}, 32'd0);
        check("abort_rst_data",  {16'd0, wData_o}, 32'd0);
        check("abort_rst_waddr", {28'd0, wRegAddr_o}, 32'd0);
        drive(ALU_ADD, 16'd2, 16'd3, 4'd1);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle_stall", {31'd0, stallReq_o}, 32'd0);
        check("post_rst_add", {16'd0, wData_o}, 32'd5);
        next_cycle();

        // Flush at BUSY cycle 5
        drive(ALU_MUL, 16'h0002, 16'h0003, 4'd7);
        @(negedge clk);
        for (int i = 0; i < 5; i++) next_cycle();
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_stall", {31'd0, stallReq_o}, 32'd0);
        check("flush_wreg",  {31'd0, wReg_o}, 32'd0);
        next_cycle();
        flush_i = 1'b0;
        drive(ALU_NOP, 16'd0, 16'd0, 4'd7);
        seen_wreg  = 1'b0;
        seen_stall = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            seen_wreg  = seen_wreg | wReg_o;
            seen_stall = seen_stall | stallReq_o;
            next_cycle();
        end
        check("flush_no_wb",    {31'd0, seen_wreg}, 32'd0);
        check("flush_no_stall", {31'd0, seen_stall}, 32'd0);

        // Flush in IDLE suppresses a multi-cycle start
        drive(ALU_MUL, 16'h0002, 16'h0003, 4'd7);
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_idle_stall", {31'd0, stallReq_o}, 32'd0);
        next_cycle();
        flush_i = 1'b0;
        drive(ALU_LI, 16'h0000, 16'hBEEF, 4'd2);
        @(negedge clk);
        check("flush_idle_nostart", {31'd0, stallReq_o}, 32'd0);
        check("li_data", {16'd0, wData_o}, 32'hBEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
